// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the execute stage and its iterative multiply/divide.
//   - ALU / muldiv opcode values (ALU_AND .. ALU_REMU)
//   - bit positions inside the wb and m control bundles
//   - muldiv FSM state encoding
// -----------------------------------------------------------------------------
package pipe_pkg;

  // ALU operation codes (compared after casting to the alu_op width)
  localparam int ALU_AND   = 0;
  localparam int ALU_OR    = 1;
  localparam int ALU_ADD   = 2;
  localparam int ALU_XOR   = 3;
  localparam int ALU_NOR   = 4;
  localparam int ALU_RSVD  = 5;
  localparam int ALU_SUB   = 6;
  localparam int ALU_SLT   = 7;
  localparam int ALU_SLTU  = 8;
  localparam int ALU_SLL   = 9;
  localparam int ALU_SRL   = 10;
  localparam int ALU_SRA   = 11;
  // Multi-cycle operations; every code from ALU_MUL upward goes to muldiv_iter
  localparam int ALU_MUL   = 12;
  localparam int ALU_MULHU = 13;
  localparam int ALU_DIVU  = 14;
  localparam int ALU_REMU  = 15;

  // wb bundle bit positions
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // m bundle bit positions
  localparam int M_BRANCH    = 2;
  localparam int M_MEM_READ  = 1;
  localparam int M_MEM_WRITE = 0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_stage_mc_if.sv
// -----------------------------------------------------------------------------
// execute_stage_mc_if
// Bundles the ID/EX inputs, the MEM/WB forwarding inputs, the stall output
// and the EX/MEM register outputs of the execute stage.
//   master : the surrounding pipeline (drives ID/EX + MEM/WB, sees EX/MEM)
//   slave  : the execute stage itself
// -----------------------------------------------------------------------------
interface execute_stage_mc_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
);
  logic                flush;
  logic                in_valid;
  logic [1:0]          wb_in;
  logic [2:0]          m_in;
  logic [XLEN-1:0]     rs_data;
  logic [XLEN-1:0]     rt_data;
  logic [XLEN-1:0]     imm;
  logic [REG_AW-1:0]   rs_addr;
  logic [REG_AW-1:0]   rt_addr;
  logic [REG_AW-1:0]   rd_addr;
  logic                reg_dst;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_wb_reg_write;
  logic [REG_AW-1:0]   mem_wb_rd;
  logic [XLEN-1:0]     mem_wb_data;
  logic                stall;
  logic                ex_mem_valid;
  logic [1:0]          ex_mem_wb;
  logic [2:0]          ex_mem_m;
  logic [XLEN-1:0]     ex_mem_result;
  logic [XLEN-1:0]     ex_mem_store_data;
  logic [REG_AW-1:0]   ex_mem_rd;
  logic                ex_mem_branch_taken;

  modport master (
    output flush, in_valid, wb_in, m_in, rs_data, rt_data, imm,
           rs_addr, rt_addr, rd_addr, reg_dst, alu_src, alu_op,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data,
    input  stall, ex_mem_valid, ex_mem_wb, ex_mem_m, ex_mem_result,
           ex_mem_store_data, ex_mem_rd, ex_mem_branch_taken
  );

  modport slave (
    input  flush, in_valid, wb_in, m_in, rs_data, rt_data, imm,
           rs_addr, rt_addr, rd_addr, reg_dst, alu_src, alu_op,
           mem_wb_reg_write, mem_wb_rd, mem_wb_data,
    output stall, ex_mem_valid, ex_mem_wb, ex_mem_m, ex_mem_result,
           ex_mem_store_data, ex_mem_rd, ex_mem_branch_taken
  );
endinterface

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle. Operands are latched on start, XLEN RUN cycles follow, then one DONE
// cycle during which result is valid.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start     issue request (honoured only in IDLE)
//   op        MUL / MULHU / DIVU / REMU code
//   a, b      operands (a = multiplicand / dividend, b = multiplier / divisor)
//   abort     kill a running operation, back to IDLE
//   busy      upstream must hold (issue cycle + every RUN cycle)
//   done      result valid this cycle
//   result    selected half of the product or quotient/remainder
// -----------------------------------------------------------------------------
module muldiv_iter
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     result
);
  localparam int CW = $clog2(XLEN);

  md_state_e           r_state;
  md_state_e           w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [ALU_OP_W-1:0] r_op;
  // {r_hi, r_lo}: product accumulator (mul) or {remainder, quotient} (div)
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic [XLEN-1:0]     r_b;

  logic                w_start_is_div;
  logic                w_run_is_div;
  logic [XLEN:0]       w_mul_sum;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN:0]       w_div_diff;

  assign w_start_is_div = (op == ALU_OP_W'(ALU_DIVU)) || (op == ALU_OP_W'(ALU_REMU));
  assign w_run_is_div   = (r_op == ALU_OP_W'(ALU_DIVU)) || (r_op == ALU_OP_W'(ALU_REMU));

  // Shift-add: add multiplicand when the current multiplier LSB is set
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  // Restoring divide: bring the next dividend bit into the partial remainder.
  // With a zero divisor the subtraction never borrows, so the quotient becomes
  // all ones and the remainder collects the whole dividend.
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_state_next = MD_RUN;
          busy         = 1'b1;
        end
      end
      MD_RUN: begin
        if (abort) begin
          w_state_next = MD_IDLE;
        end else begin
          busy = 1'b1;
          if (r_cnt == '0) w_state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        w_state_next = MD_IDLE;
        done         = !abort;
      end
      default: w_state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (r_state == MD_IDLE && start) begin
      r_cnt <= CW'(XLEN - 1);
      r_op  <= op;
      r_hi  <= '0;
      if (w_start_is_div) begin
        r_lo <= a;
        r_b  <= b;
      end else begin
        r_lo <= b;
        r_b  <= a;
      end
    end else if (r_state == MD_RUN && !abort) begin
      r_cnt <= r_cnt - 1'b1;
      if (w_run_is_div) begin
        if (!w_div_diff[XLEN]) begin
          r_hi <= w_div_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // MULHU and REMU read the upper register, MUL and DIVU the lower one
  assign result = ((r_op == ALU_OP_W'(ALU_MULHU)) || (r_op == ALU_OP_W'(ALU_REMU))) ? r_hi : r_lo;

endmodule

// File: rtl/execute_stage_mc.sv
// -----------------------------------------------------------------------------
// execute_stage_mc
// Execute stage: forwarding muxes for rs/rt, single-cycle ALU, iterative
// muldiv (stalls upstream) and the EX/MEM pipeline register.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    execute_stage_mc_if.slave: ID/EX inputs, flush, MEM/WB forward
//          inputs, stall output, EX/MEM register outputs
// -----------------------------------------------------------------------------
module execute_stage_mc
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
) (
  input logic              clock,
  input logic              reset,
  execute_stage_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic              r_valid;
  logic [1:0]        r_wb;
  logic [2:0]        r_m;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_store_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_branch_taken;

  logic [REG_AW-1:0] w_src_addr [2];
  logic [XLEN-1:0]   w_src_data [2];
  logic [XLEN-1:0]   w_fwd      [2];
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu_result;
  logic [REG_AW-1:0] w_dest;
  logic              w_is_md;
  logic              w_md_start;
  logic              w_md_busy;
  logic              w_md_done;
  logic [XLEN-1:0]   w_md_result;

  assign w_src_addr[0] = bus.rs_addr;
  assign w_src_addr[1] = bus.rt_addr;
  assign w_src_data[0] = bus.rs_data;
  assign w_src_data[1] = bus.rt_data;

  // Per-source forwarding: EX/MEM beats MEM/WB; r0 is never forwarded
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_hit_exmem;
      logic w_hit_memwb;
      assign w_hit_exmem = r_valid && r_wb[WB_REG_WRITE] && (r_rd != '0) &&
                           (r_rd == w_src_addr[gi]);
      assign w_hit_memwb = bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) &&
                           (bus.mem_wb_rd == w_src_addr[gi]);
      assign w_fwd[gi]   = w_hit_exmem ? r_result :
                           (w_hit_memwb ? bus.mem_wb_data : w_src_data[gi]);
    end
  endgenerate

  assign w_a     = w_fwd[0];
  assign w_b     = bus.alu_src ? bus.imm : w_fwd[1];
  assign w_shamt = w_b[SHW-1:0];
  assign w_dest  = bus.reg_dst ? bus.rd_addr : bus.rt_addr;

  always_comb begin
    w_alu_result = '0;
    case (bus.alu_op)
      ALU_OP_W'(ALU_AND):  w_alu_result = w_a & w_b;
      ALU_OP_W'(ALU_OR):   w_alu_result = w_a | w_b;
      ALU_OP_W'(ALU_ADD):  w_alu_result = w_a + w_b;
      ALU_OP_W'(ALU_XOR):  w_alu_result = w_a ^ w_b;
      ALU_OP_W'(ALU_NOR):  w_alu_result = ~(w_a | w_b);
      ALU_OP_W'(ALU_SUB):  w_alu_result = w_a - w_b;
      ALU_OP_W'(ALU_SLT):  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_OP_W'(ALU_SLTU): w_alu_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      ALU_OP_W'(ALU_SLL):  w_alu_result = w_a << w_shamt;
      ALU_OP_W'(ALU_SRL):  w_alu_result = w_a >> w_shamt;
      ALU_OP_W'(ALU_SRA):  w_alu_result = $unsigned($signed(w_a) >>> w_shamt);
      default:             w_alu_result = '0;
    endcase
  end

  // A flushed or invalid instruction never starts the muldiv. Reset is
  // included so stall reads 0 while reset is held, even with an issue pending.
  assign w_is_md    = (bus.alu_op >= ALU_OP_W'(ALU_MUL));
  assign w_md_start = bus.in_valid && w_is_md && !bus.flush && !reset;

  muldiv_iter #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W)
  ) u_muldiv (
    .clk    (clock),
    .rst    (reset),
    .start  (w_md_start),
    .op     (bus.alu_op),
    .a      (w_a),
    .b      (w_b),
    .abort  (bus.flush),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );

  assign bus.stall = w_md_busy;

  // EX/MEM register. In the DONE cycle the muldiv instruction is still held in
  // ID/EX, so its control bits and destination come straight from the inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_wb           <= '0;
      r_m            <= '0;
      r_result       <= '0;
      r_store_data   <= '0;
      r_rd           <= '0;
      r_branch_taken <= 1'b0;
    end else if (bus.flush || w_md_busy || !bus.in_valid) begin
      r_valid        <= 1'b0;
      r_wb           <= '0;
      r_m            <= '0;
      r_result       <= '0;
      r_store_data   <= '0;
      r_rd           <= '0;
      r_branch_taken <= 1'b0;
    end else begin
      r_valid        <= 1'b1;
      r_wb           <= bus.wb_in;
      r_m            <= bus.m_in;
      r_result       <= w_md_done ? w_md_result : w_alu_result;
      r_store_data   <= w_fwd[1];
      r_rd           <= w_dest;
      r_branch_taken <= bus.m_in[M_BRANCH] && (w_fwd[0] == w_fwd[1]);
    end
  end

  assign bus.ex_mem_valid        = r_valid;
  assign bus.ex_mem_wb           = r_wb;
  assign bus.ex_mem_m            = r_m;
  assign bus.ex_mem_result       = r_result;
  assign bus.ex_mem_store_data   = r_store_data;
  assign bus.ex_mem_rd           = r_rd;
  assign bus.ex_mem_branch_taken = r_branch_taken;

endmodule

// File: tb/tb_execute_stage_mc.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_mc
// Directed bench for execute_stage_mc: forwarding, ALU ops, muldiv latency,
// flush abort, asynchronous reset mid-operation and branch compare.
// -----------------------------------------------------------------------------
module tb_execute_stage_mc;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ALU_OP_W = 4;

  localparam int OP_AND = 0,  OP_OR = 1,  OP_ADD = 2,  OP_XOR = 3,  OP_NOR = 4;
  localparam int OP_RSV = 5,  OP_SUB = 6, OP_SLT = 7,  OP_SLTU = 8, OP_SLL = 9;
  localparam int OP_SRL = 10, OP_SRA = 11, OP_MUL = 12, OP_MULHU = 13;
  localparam int OP_DIVU = 14, OP_REMU = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_mc_if #(.XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)) bus ();

  execute_stage_mc #(.XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    string             tag;
    logic [XLEN-1:0]   data;
    logic [REG_AW-1:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [XLEN-1:0] data, input int rd);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    e.rd   = REG_AW'(rd);
    sb_q.push_back(e);
  endtask

  // Compare the EX/MEM register against the oldest expected result
  task automatic sb_check();
    exp_t e;
    chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_valid"},  64'(bus.ex_mem_valid),  64'd1);
      chk({e.tag, "_result"}, 64'(bus.ex_mem_result), 64'(e.data));
      chk({e.tag, "_rd"},     64'(bus.ex_mem_rd),     64'(e.rd));
      $display("txn %-16s result=0x%08h rd=%0d", e.tag, bus.ex_mem_result, bus.ex_mem_rd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.wb_in = 2'b00;  bus.m_in = 3'b000;
    bus.rs_data = '0;  bus.rt_data = '0;  bus.imm = '0;
    bus.rs_addr = '0;  bus.rt_addr = '0;  bus.rd_addr = '0;
    bus.reg_dst = 1'b1;  bus.alu_src = 1'b0;  bus.alu_op = '0;
    bus.mem_wb_reg_write = 1'b0;  bus.mem_wb_rd = '0;  bus.mem_wb_data = '0;
  endtask

  task automatic set_alu(input int op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int rs, input int rt, input int rd);
    bus.flush = 1'b0;  bus.in_valid = 1'b1;  bus.wb_in = 2'b10;  bus.m_in = 3'b000;
    bus.alu_op = ALU_OP_W'(op);
    bus.rs_data = a;  bus.rt_data = b;  bus.imm = '0;
    bus.rs_addr = REG_AW'(rs);  bus.rt_addr = REG_AW'(rt);  bus.rd_addr = REG_AW'(rd);
    bus.reg_dst = 1'b1;  bus.alu_src = 1'b0;
  endtask

  // Issue a muldiv, count stall cycles (issue + RUN), then check the result
  task automatic run_md(input int op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input string tag, input logic [XLEN-1:0] exp);
    int n;
    set_alu(op, a, b, 21, 22, 20);
    sb_push(tag, exp, 20);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(XLEN + 1));
    chk({tag, "_bubble"}, 64'(bus.ex_mem_valid), 64'd0);
    tick();
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen_valid;
    int  seen_stall;

    // ---------------- reset state ----------------
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid",  64'(bus.ex_mem_valid),  64'd0);
    chk("rst_result", 64'(bus.ex_mem_result), 64'd0);
    chk("rst_wb",     64'(bus.ex_mem_wb),     64'd0);
    chk("rst_stall",  64'(bus.stall),         64'd0);
    #3 rst = 1'b0;
    tick();

    // ---------------- 1: EX/MEM forwarding ----------------
    set_alu(OP_ADD, 5, 7, 1, 2, 3);
    sb_push("add_r3", 12, 3);
    tick();
    sb_check();
    set_alu(OP_SUB, 100, 1, 3, 3, 4);  // stale regfile values would give 99
    sb_push("sub_fwd_exmem", 0, 4);
    tick();
    sb_check();

    // ---------------- 2: priority and r0 suppression ----------------
    set_alu(OP_ADD, 4, 5, 6, 7, 2);
    sb_push("add_r2", 9, 2);
    tick();
    sb_check();
    bus.mem_wb_reg_write = 1'b1;  bus.mem_wb_rd = 5'd2;  bus.mem_wb_data = 4;
    set_alu(OP_OR, 32'h100, 0, 2, 0, 8);
    bus.alu_src = 1'b1;
    sb_push("fwd_exmem_prio", 9, 8);
    tick();
    sb_check();
    set_alu(OP_OR, 32'h100, 0, 2, 0, 9);
    bus.alu_src = 1'b1;
    sb_push("fwd_memwb", 4, 9);
    tick();
    sb_check();
    bus.mem_wb_rd = 5'd0;  bus.mem_wb_data = 32'hFFFF;
    set_alu(OP_OR, 32'hFFFF, 0, 13, 0, 0);
    bus.alu_src = 1'b1;
    sb_push("write_r0", 32'hFFFF, 0);
    tick();
    sb_check();
    set_alu(OP_OR, 3, 0, 0, 0, 10);
    bus.alu_src = 1'b1;
    sb_push("r0_no_fwd", 3, 10);
    tick();
    sb_check();
    bus.mem_wb_reg_write = 1'b0;

    // ---------------- 3: muldiv ----------------
    run_md(OP_MUL,   32'h10000, 32'h10000, "mul",      32'h0);
    run_md(OP_MULHU, 32'h10000, 32'h10000, "mulhu",    32'h1);
    run_md(OP_DIVU,  100,       7,         "divu",     14);
    run_md(OP_REMU,  100,       7,         "remu",     2);
    run_md(OP_DIVU,  100,       0,         "divu_z",   32'hFFFF_FFFF);
    run_md(OP_REMU,  100,       0,         "remu_z",   100);
    run_md(OP_MUL,   32'h1234,  32'h10,    "mul_b",    32'h12340);

    // ---------------- 4: flush abort at RUN cycle 10 ----------------
    set_alu(OP_DIVU, 1000, 3, 21, 22, 20);
    #1;
    chk("flush_issue_stall", 64'(bus.stall), 64'd1);
    repeat (10) tick();
    chk("flush_run10_stall", 64'(bus.stall), 64'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall_drop", 64'(bus.stall), 64'd0);
    tick();
    chk("flush_bubble", 64'(bus.ex_mem_valid), 64'd0);
    set_alu(OP_ADD, 3, 4, 21, 22, 20);
    sb_push("add_after_flush", 7, 20);
    #1;
    chk("flush_fsm_idle", 64'(bus.stall), 64'd0);
    tick();
    sb_check();

    // ---------------- single-cycle flush and in_valid=0 ----------------
    set_alu(OP_ADD, 1, 2, 21, 22, 20);
    bus.flush = 1'b1;
    tick();
    chk("flush_single_bubble", 64'(bus.ex_mem_valid), 64'd0);
    set_alu(OP_ADD, 1, 2, 21, 22, 20);
    bus.in_valid = 1'b0;
    tick();
    chk("invalid_bubble", 64'(bus.ex_mem_valid), 64'd0);

    // ---------------- 5: asynchronous reset ----------------
    set_alu(OP_ADD, 1, 1, 21, 22, 20);
    sb_push("add_pre_rst", 2, 20);
    tick();
    sb_check();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",  64'(bus.ex_mem_valid),  64'd0);
    chk("arst_result", 64'(bus.ex_mem_result), 64'd0);
    chk("arst_rd",     64'(bus.ex_mem_rd),     64'd0);
    #1 rst = 1'b0;
    tick();
    set_alu(OP_DIVU, 100, 7, 21, 22, 20);
    #1;
    chk("rst_run_issue_stall", 64'(bus.stall), 64'd1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_run_stall", 64'(bus.stall), 64'd0);
    chk("rst_run_valid", 64'(bus.ex_mem_valid), 64'd0);
    set_idle();
    tick();
    tick();
    #2 rst = 1'b0;
    seen_valid = 0;
    seen_stall = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ex_mem_valid !== 1'b0) seen_valid++;
      if (bus.stall !== 1'b0) seen_stall++;
    end
    chk("rst_no_stale_result", 64'(seen_valid), 64'd0);
    chk("rst_no_stale_stall",  64'(seen_stall), 64'd0);
    set_alu(OP_ADD, 8, 9, 21, 22, 20);
    sb_push("add_after_rst", 17, 20);
    tick();
    sb_check();

    // ---------------- 6: branch, shifts, compares, misc ALU ----------------
    set_alu(OP_SUB, 32'hA5, 32'hA5, 21, 22, 20);
    bus.m_in = 3'b100;  bus.wb_in = 2'b00;  bus.alu_src = 1'b1;  bus.imm = 5;
    tick();
    chk("beq_taken", 64'(bus.ex_mem_branch_taken), 64'd1);
    chk("beq_m",     64'(bus.ex_mem_m),            64'd4);
    chk("beq_wb",    64'(bus.ex_mem_wb),           64'd0);
    set_alu(OP_SUB, 32'hA5, 32'hA4, 21, 22, 20);
    bus.m_in = 3'b100;  bus.wb_in = 2'b00;  bus.alu_src = 1'b1;  bus.imm = 32'hA5;
    tick();
    chk("bne_not_taken", 64'(bus.ex_mem_branch_taken), 64'd0);

    set_alu(OP_SRA, 32'h8000_0000, 0, 21, 22, 20);
    bus.alu_src = 1'b1;  bus.imm = 4;
    sb_push("sra", 32'hF800_0000, 20);
    tick();
    sb_check();
    set_alu(OP_SRL, 32'h8000_0000, 0, 21, 22, 20);
    bus.alu_src = 1'b1;  bus.imm = 4;
    sb_push("srl", 32'h0800_0000, 20);
    tick();
    sb_check();
    set_alu(OP_SLL, 1, 0, 21, 22, 20);
    bus.alu_src = 1'b1;  bus.imm = 32'h0000_0FFF;  // only low 5 bits (31) count
    sb_push("sll", 32'h8000_0000, 20);
    tick();
    sb_check();
    set_alu(OP_SLTU, 32'hFFFF_FFFF, 1, 21, 22, 20);
    sb_push("sltu", 0, 20);
    tick();
    sb_check();
    set_alu(OP_SLT, 32'hFFFF_FFFF, 1, 21, 22, 20);
    sb_push("slt", 1, 20);
    tick();
    sb_check();
    set_alu(OP_ADD, 32'hFFFF_FFFF, 2, 21, 22, 20);
    sb_push("add_wrap", 1, 20);
    tick();
    sb_check();
    set_alu(OP_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 21, 22, 20);
    sb_push("nor", 32'h0F0F_F0F0, 20);
    tick();
    sb_check();
    set_alu(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 21, 22, 20);
    sb_push("xor", 32'hF0F0_F0F0, 20);
    tick();
    sb_check();
    set_alu(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 21, 22, 20);
    sb_push("and", 32'h0F00_0F00, 20);
    tick();
    sb_check();
    set_alu(OP_RSV, 32'h1234_5678, 32'h1, 21, 22, 20);
    sb_push("reserved", 0, 20);
    tick();
    sb_check();
    set_alu(OP_ADD, 32'h11, 32'h22, 21, 22, 7);
    bus.reg_dst = 1'b0;  // destination taken from rt field
    sb_push("reg_dst_rt", 32'h33, 22);
    tick();
    chk("store_data", 64'(bus.ex_mem_store_data), 64'h22);
    sb_check();

    set_idle();
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised execute stage for the 5-stage pipeline. It contains:
- two 3-way forwarding muxes with an internal forwarding unit
- single-cycle ALU
- iterative multi-cycle unsigned multiply/divide unit that stalls upstream stages
- registered EX/MEM pipeline register

It sits between the ID/EX register and the memory stage. Relative to the previous stage it adds width generics, a flush, a muldiv stall handshake and register-0 forwarding suppression.

Parameters:
XLEN, 32, datapath width (>=8, power of 2)
REG_AW, 5, register address width
ALU_OP_W, 4, alu_op width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  kill instruction currently in EX
in_valid  in  1  ID/EX holds a real instruction
wb_in  in  2  [1]=reg_write, [0]=mem_to_reg
m_in  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
rs_data, rt_data  in  XLEN  register-file operands
imm  in  XLEN  sign-extended immediate
rs_addr, rt_addr, rd_addr  in  REG_AW  source and destination fields
reg_dst  in  1  1: dest=rd_addr, 0: dest=rt_addr
alu_src  in  1  1: operand B=imm, 0: forwarded rt
alu_op  in  ALU_OP_W  operation select
mem_wb_reg_write  in  1  WB-stage write enable
mem_wb_rd  in  REG_AW  WB-stage destination
mem_wb_data  in  XLEN  WB-stage write data
stall  out  1  hold PC/IF/ID/ID-EX this cycle
ex_mem_valid, ex_mem_wb, ex_mem_m, ex_mem_result, ex_mem_store_data, ex_mem_rd, ex_mem_branch_taken  out  1/2/3/XLEN/XLEN/REG_AW/1  EX/MEM register

Behaviour:
- Reset: all ex_mem_* outputs are 0, the FSM is IDLE and stall=0. Reset mid-muldiv aborts the operation and no result is written.
- Forwarding (combinational), applied per source (rs, rt):
  - EX/MEM forward if ex_mem_valid & ex_mem_wb[1] & ex_mem_rd!=0 & ex_mem_rd==src.
  - Otherwise MEM/WB forward if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==src.
  - Otherwise use the register-file value. EX/MEM has priority.
- Operands: A=fwd_rs; B = alu_src ? imm : fwd_rt. ex_mem_store_data=fwd_rt.
- ALU op codes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB
  - 7 SLT signed, 8 SLTU
  - 9 SLL, 10 SRL, 11 SRA; shift amount = B[$clog2(XLEN)-1:0]
  - 5 reserved, result=0
  - ADD/SUB wrap modulo 2^XLEN with no overflow trap.
- Muldiv op codes: 12 MUL (low XLEN bits), 13 MULHU (high XLEN bits), 14 DIVU, 15 REMU.
- Divide by zero: DIVU returns all ones; REMU returns the dividend.
- Muldiv FSM has three states: IDLE, RUN, DONE.
  - IDLE: when in_valid & op>=12 & !flush, capture A, B and the op, load the counter with XLEN-1, go to RUN. stall=1 combinationally in this same cycle.
  - RUN: one shift-add or restoring-subtract step per cycle; stall=1. When the counter reaches 0, go to DONE.
  - DONE: stall=0. The result is written into EX/MEM at this edge, then return to IDLE.
  - Total stall cycles = XLEN+1. The result appears on ex_mem_result XLEN+2 edges after issue.
  - Operands are latched at issue, so forwarding changes during RUN are ignored.
- While stall=1 the EX/MEM register loads a bubble: valid=0, wb=0, m=0, and result/rd are don't-care but driven 0.
- Branch: ex_mem_branch_taken = m_in[2] & (fwd_rs==fwd_rt). The branch uses forwarded registers, never imm.
- flush:
  - Forces a bubble into EX/MEM on that edge.
  - In RUN or DONE it aborts the FSM to IDLE and deasserts stall in the same cycle.
  - flush together with a new muldiv issue: flush wins and the FSM stays IDLE.
- in_valid=0: a bubble is loaded and the FSM does not start.
- Single-cycle ops register their result at the next edge (latency 1) with stall=0.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU opcode constants (ALU_AND..ALU_REMU)
  - wb/m bit-index constants
  - FSM state enum MD_IDLE/MD_RUN/MD_DONE
- One sub-module: muldiv_iter. It has start, op, a, b, abort, busy, done and result ports and owns the FSM and counter.
- The forwarding logic stays inline.

Test Plan:
1. Forwarding priority, EX/MEM: ADD r3=5+7, then SUB r4=r3-r3 back-to-back. Required: second result uses forwarded 12, ex_mem_result=0.
2. Forwarding priority, MEM/WB and r0: with EX/MEM rd=2 (data 9) and MEM/WB rd=2 (data 4), rs=2 -> A=9. With both destinations at r0 holding data 0xFFFF, A=rs_data.
3. Muldiv latency: XLEN=32, MUL 0x10000*0x10000. Required: stall high 33 cycles, ex_mem_result=0; MULHU gives 1. DIVU 100/7 gives 14, REMU gives 2. DIVU x/0 gives 0xFFFFFFFF.
4. Flush abort: flush at RUN cycle 10 of a DIVU. Required: stall drops the same cycle, bubble in EX/MEM, next ADD completes normally.
5. Reset mid-RUN: assert reset asynchronously. Required: all outputs 0 immediately, FSM IDLE, no stale result after release.
6. Branch and shift: BEQ with rs=rt=0xA5 -> ex_mem_branch_taken=1. SRA of 0x80000000 by 4 -> 0xF8000000. SLTU of -1 vs 1 -> 0; SLT of -1 vs 1 -> 1.
